// File: rtl/mc_ctrl_seq.sv
// mc_ctrl_seq: multicycle control sequencer for the 32-bit MIPS datapath.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB and handshakes with
// a variable-latency memory through mem_ready.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   run               enable, sampled in IDLE and at instruction boundaries
//   opcode            instruction register bits [31:26]
//   zero              ALU zero flag (branch qualification)
//   mem_ready         memory completes the current access this cycle
//   pc_en .. alu_op   datapath control (Moore decode of state; ir_write,
//                     pc_en and the memory strobes also depend on zero/mem_ready)
//   busy              high in every state except IDLE and TRAP
//   illegal_op        sticky, unsupported opcode decoded
//   mem_err           sticky, memory access timed out
//   state_dbg         current state encoding
//
// Optional feature (macro MC_CTRL_PERF_EN): adds retired[31:0] and
// stall_cyc[31:0] performance counters. Undefined by default.
//
// Outputs are combinational decodes of the state register so that the
// mem_ready/zero-qualified strobes take effect in the same cycle.
module mc_ctrl_seq #(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned STATE_W     = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    input  logic [5:0]         opcode,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               pc_en,
    output logic [1:0]         pc_src,
    output logic               iord,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op,
    output logic               busy,
    output logic               illegal_op,
    output logic               mem_err,
    output logic [STATE_W-1:0] state_dbg
`ifdef MC_CTRL_PERF_EN
    ,
    output logic [31:0]        retired,
    output logic [31:0]        stall_cyc
`endif
);

    localparam int unsigned CNT_W = 8;

    localparam logic [STATE_W-1:0] S_IDLE   = STATE_W'(0);
    localparam logic [STATE_W-1:0] S_FETCH  = STATE_W'(1);
    localparam logic [STATE_W-1:0] S_DECODE = STATE_W'(2);
    localparam logic [STATE_W-1:0] S_MEMADR = STATE_W'(3);
    localparam logic [STATE_W-1:0] S_MEMRD  = STATE_W'(4);
    localparam logic [STATE_W-1:0] S_MEMWB  = STATE_W'(5);
    localparam logic [STATE_W-1:0] S_MEMWR  = STATE_W'(6);
    localparam logic [STATE_W-1:0] S_REXEC  = STATE_W'(7);
    localparam logic [STATE_W-1:0] S_RWB    = STATE_W'(8);
    localparam logic [STATE_W-1:0] S_BRANCH = STATE_W'(9);
    localparam logic [STATE_W-1:0] S_JUMP   = STATE_W'(10);
    localparam logic [STATE_W-1:0] S_IEXEC  = STATE_W'(11);
    localparam logic [STATE_W-1:0] S_IWB    = STATE_W'(12);
    localparam logic [STATE_W-1:0] S_TRAP   = STATE_W'(15);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // Count value seen in the last allowed waiting cycle.
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(MEM_TIMEOUT - 1);

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] nextState;
    logic [CNT_W-1:0]   waitCnt;
    logic               memWait;
    logic               timeoutHit;
    logic               setIllegal;
    logic [STATE_W-1:0] doneNext;

    // States that wait on the memory handshake.
    assign memWait    = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
    // This waiting cycle is the last one allowed and memory is still not ready.
    assign timeoutHit = memWait && !mem_ready && (waitCnt == TO_LAST);
    // Instruction boundary: run decides whether to fetch again.
    assign doneNext   = run ? S_FETCH : S_IDLE;
    assign state_dbg  = state;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Wait counter: runs while stalled, zero otherwise, so every wait state
    // is entered with a cleared count.
    always_ff @(posedge clk) begin
        if (reset) begin
            waitCnt <= '0;
        end else if (memWait && !mem_ready && !timeoutHit) begin
            waitCnt <= waitCnt + CNT_W'(1);
        end else begin
            waitCnt <= '0;
        end
    end

    // Sticky error flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            illegal_op <= 1'b0;
            mem_err    <= 1'b0;
        end else begin
            if (setIllegal) illegal_op <= 1'b1;
            if (timeoutHit) mem_err    <= 1'b1;
        end
    end

    // Next state and control decode. While reset is high every output is
    // held at zero so an abandoned instruction emits no further strobes.
    always_comb begin
        nextState  = state;
        setIllegal = 1'b0;
        pc_en      = 1'b0;
        pc_src     = 2'b00;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        busy       = 1'b0;

        if (!reset) begin
            busy = (state != S_IDLE) && (state != S_TRAP);
            case (state)
                S_IDLE: begin
                    if (run) nextState = S_FETCH;
                end
                S_FETCH: begin
                    alu_src_b = 2'b01;
                    if (timeoutHit) begin
                        nextState = S_TRAP;
                    end else begin
                        mem_read = 1'b1;
                        ir_write = mem_ready;
                        pc_en    = mem_ready;
                        if (mem_ready) nextState = S_DECODE;
                    end
                end
                S_DECODE: begin
                    alu_src_b = 2'b11;
                    case (opcode)
                        OP_LW, OP_SW: nextState = S_MEMADR;
                        OP_RTYPE:     nextState = S_REXEC;
                        OP_BEQ:       nextState = S_BRANCH;
                        OP_J:         nextState = S_JUMP;
                        OP_ADDI:      nextState = S_IEXEC;
                        default: begin
                            nextState  = S_TRAP;
                            setIllegal = 1'b1;
                        end
                    endcase
                end
                S_MEMADR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    nextState = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
                end
                S_MEMRD: begin
                    iord = 1'b1;
                    if (timeoutHit) begin
                        nextState = S_TRAP;
                    end else begin
                        mem_read = 1'b1;
                        if (mem_ready) nextState = S_MEMWB;
                    end
                end
                S_MEMWB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    nextState  = doneNext;
                end
                S_MEMWR: begin
                    iord = 1'b1;
                    if (timeoutHit) begin
                        nextState = S_TRAP;
                    end else begin
                        mem_write = 1'b1;
                        if (mem_ready) nextState = doneNext;
                    end
                end
                S_REXEC: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b10;
                    nextState = S_RWB;
                end
                S_RWB: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                    nextState = doneNext;
                end
                S_BRANCH: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b01;
                    pc_src    = 2'b01;
                    pc_en     = zero;
                    nextState = doneNext;
                end
                S_JUMP: begin
                    pc_src    = 2'b10;
                    pc_en     = 1'b1;
                    nextState = doneNext;
                end
                S_IEXEC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    nextState = S_IWB;
                end
                S_IWB: begin
                    reg_write = 1'b1;
                    nextState = doneNext;
                end
                S_TRAP: begin
                    nextState = S_TRAP;
                end
                default: begin
                    // Unused encodings recover to IDLE.
                    nextState = S_IDLE;
                end
            endcase
        end
    end

`ifdef MC_CTRL_PERF_EN
    logic retireNow;

    // Final cycle of a completed instruction.
    assign retireNow = (state == S_MEMWB) || (state == S_RWB) || (state == S_BRANCH) ||
                       (state == S_JUMP)  || (state == S_IWB) ||
                       ((state == S_MEMWR) && mem_ready);

    // Retired-instruction and memory-stall counters, wrapping modulo 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            retired   <= '0;
            stall_cyc <= '0;
        end else begin
            if (retireNow)            retired   <= retired + 32'd1;
            if (memWait && !mem_ready) stall_cyc <= stall_cyc + 32'd1;
        end
    end
`else
    // Performance counters not built.
`endif

endmodule

// File: tb/tb_mc_ctrl_seq.sv
// Bench for mc_ctrl_seq: builds an expected per-cycle trace from instruction
// descriptions (opcode, zero, stall lengths, run at completion), then drives
// it cycle by cycle and compares state, controls and sticky flags.
module tb_mc_ctrl_seq;

    localparam int unsigned TO = 4;

    localparam logic [3:0] IDLE   = 4'd0;
    localparam logic [3:0] FETCH  = 4'd1;
    localparam logic [3:0] DECODE = 4'd2;
    localparam logic [3:0] MEMADR = 4'd3;
    localparam logic [3:0] MEMRD  = 4'd4;
    localparam logic [3:0] MEMWB  = 4'd5;
    localparam logic [3:0] MEMWR  = 4'd6;
    localparam logic [3:0] REXEC  = 4'd7;
    localparam logic [3:0] RWB    = 4'd8;
    localparam logic [3:0] BRANCH = 4'd9;
    localparam logic [3:0] JUMP   = 4'd10;
    localparam logic [3:0] IEXEC  = 4'd11;
    localparam logic [3:0] IWB    = 4'd12;
    localparam logic [3:0] TRAP   = 4'd15;

    localparam logic [5:0] LW = 6'h23, SW = 6'h2B, RT = 6'h00, BEQ = 6'h04, JMP = 6'h02, ADDI = 6'h08;

    typedef struct packed {
        logic       pcEn;
        logic [1:0] pcSrc;
        logic       iord;
        logic       memRead;
        logic       memWrite;
        logic       irWrite;
        logic       regDst;
        logic       memToReg;
        logic       regWrite;
        logic       srcA;
        logic [1:0] srcB;
        logic [1:0] aluOp;
        logic       busy;
    } ctl_t;

    typedef struct packed {
        logic       rst;
        logic       run;
        logic       rdy;
        logic       zero;
        logic [5:0] op;
        logic       chk;
        logic [3:0] st;
        ctl_t       ctl;
        logic       ill;
        logic       err;
    } step_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b1;
    logic       run = 1'b0;
    logic [5:0] opcode = 6'h00;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
    logic       alu_src_a, busy, illegal_op, mem_err;
    logic [1:0] pc_src, alu_src_b, alu_op;
    logic [3:0] state_dbg;
`ifdef MC_CTRL_PERF_EN
    logic [31:0] retired, stallCyc;
`endif

    mc_ctrl_seq #(.MEM_TIMEOUT(TO), .STATE_W(4)) dut (
        .clk(clk), .reset(reset), .run(run), .opcode(opcode), .zero(zero),
        .mem_ready(mem_ready), .pc_en(pc_en), .pc_src(pc_src), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .busy(busy), .illegal_op(illegal_op), .mem_err(mem_err),
        .state_dbg(state_dbg)
`ifdef MC_CTRL_PERF_EN
        , .retired(retired), .stall_cyc(stallCyc)
`endif
    );

    step_t      q[$];
    logic [5:0] curOp = 6'h00;
    logic       curZero = 1'b0;
    logic       mIll = 1'b0;
    logic       mErr = 1'b0;
    int         nCmp = 0;
    int         nBad = 0;

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic ctl_t busyCtl();
        ctl_t c;
        c = '0;
        c.busy = 1'b1;
        return c;
    endfunction

    task automatic push(input logic [3:0] st, input ctl_t c, input logic rdy, input logic rn);
        step_t s;
        s.rst = 1'b0; s.run = rn; s.rdy = rdy; s.zero = curZero; s.op = curOp;
        s.chk = 1'b1; s.st = st; s.ctl = c; s.ill = mIll; s.err = mErr;
        q.push_back(s);
    endtask

    // A reset cycle: unchecked, clears the sticky flags for later cycles.
    task automatic pushReset(input logic [3:0] st);
        step_t s;
        s = '0;
        s.rst = 1'b1; s.op = curOp; s.st = st;
        q.push_back(s);
        mIll = 1'b0;
        mErr = 1'b0;
    endtask

    // Memory wait phase with 'stall' not-ready cycles before mem_ready.
    task automatic memPhase(input logic [3:0] st, input int stall, input logic lastRun,
                            output logic trapped);
        ctl_t c;
        trapped = 1'b0;
        for (int i = 0; i <= stall; i++) begin
            c = busyCtl();
            if (st == FETCH) c.srcB = 2'b01;
            else c.iord = 1'b1;
            if (i < stall && i == int'(TO) - 1) begin
                push(st, c, 1'b0, rbit());
                mErr = 1'b1;
                trapped = 1'b1;
                return;
            end
            if (st == MEMWR) c.memWrite = 1'b1;
            else c.memRead = 1'b1;
            if (i == stall) begin
                if (st == FETCH) begin
                    c.irWrite = 1'b1;
                    c.pcEn = 1'b1;
                end
                push(st, c, 1'b1, lastRun);
            end else begin
                push(st, c, 1'b0, rbit());
            end
        end
    endtask

    task automatic trapTail();
        ctl_t c;
        c = '0;
        for (int i = 0; i < 3; i++) push(TRAP, c, rbit(), rbit());
        pushReset(TRAP);
        push(IDLE, c, rbit(), 1'b0);
        push(IDLE, c, rbit(), 1'b1);
    endtask

    task automatic idleGap(input logic endRun);
        ctl_t c;
        int n;
        c = '0;
        if (!endRun) begin
            n = $urandom_range(0, 2);
            for (int i = 0; i < n; i++) push(IDLE, c, rbit(), 1'b0);
            push(IDLE, c, rbit(), 1'b1);
        end
    endtask

    // One instruction from FETCH to its final cycle (or to TRAP and recovery).
    task automatic doInstr(input logic [5:0] op, input logic z, input int fs, input int ms,
                           input logic endRun);
        logic tr;
        ctl_t c;
        curOp = op;
        curZero = z;
        memPhase(FETCH, fs, rbit(), tr);
        if (tr) begin trapTail(); return; end
        c = busyCtl(); c.srcB = 2'b11;
        push(DECODE, c, rbit(), rbit());
        if (op == LW || op == SW) begin
            c = busyCtl(); c.srcA = 1'b1; c.srcB = 2'b10;
            push(MEMADR, c, rbit(), rbit());
            if (op == LW) begin
                memPhase(MEMRD, ms, rbit(), tr);
                if (tr) begin trapTail(); return; end
                c = busyCtl(); c.regWrite = 1'b1; c.memToReg = 1'b1;
                push(MEMWB, c, rbit(), endRun);
            end else begin
                memPhase(MEMWR, ms, endRun, tr);
                if (tr) begin trapTail(); return; end
            end
        end else if (op == RT) begin
            c = busyCtl(); c.srcA = 1'b1; c.aluOp = 2'b10;
            push(REXEC, c, rbit(), rbit());
            c = busyCtl(); c.regWrite = 1'b1; c.regDst = 1'b1;
            push(RWB, c, rbit(), endRun);
        end else if (op == BEQ) begin
            c = busyCtl(); c.srcA = 1'b1; c.aluOp = 2'b01; c.pcSrc = 2'b01; c.pcEn = z;
            push(BRANCH, c, rbit(), endRun);
        end else if (op == JMP) begin
            c = busyCtl(); c.pcSrc = 2'b10; c.pcEn = 1'b1;
            push(JUMP, c, rbit(), endRun);
        end else if (op == ADDI) begin
            c = busyCtl(); c.srcA = 1'b1; c.srcB = 2'b10;
            push(IEXEC, c, rbit(), rbit());
            c = busyCtl(); c.regWrite = 1'b1;
            push(IWB, c, rbit(), endRun);
        end else begin
            mIll = 1'b1;
            trapTail();
            return;
        end
        idleGap(endRun);
    endtask

    function automatic int randStall();
        int r;
        r = $urandom_range(0, 9);
        if (r < 5) return 0;
        if (r < 9) return $urandom_range(1, 3);
        return $urandom_range(3, 5);
    endfunction

    initial begin
        step_t s;
        ctl_t  act;
        logic [5:0] ops [7];
        logic tr;
        ops[0] = LW; ops[1] = SW; ops[2] = RT; ops[3] = BEQ; ops[4] = JMP; ops[5] = ADDI; ops[6] = 6'h3F;

        // Reset two cycles with run low, idle, then start.
        pushReset(IDLE);
        pushReset(IDLE);
        push(IDLE, '0, 1'b0, 1'b0);
        push(IDLE, '0, 1'b1, 1'b1);

        doInstr(LW, 1'b0, 0, 0, 1'b1);
        doInstr(SW, 1'b0, 0, 3, 1'b1);
        doInstr(BEQ, 1'b1, 0, 0, 1'b1);
        doInstr(BEQ, 1'b0, 0, 0, 1'b1);
        doInstr(RT, 1'b0, 1, 0, 1'b0);
        doInstr(JMP, 1'b0, 0, 0, 1'b0);
        doInstr(ADDI, 1'b1, 3, 0, 1'b1);
        doInstr(LW, 1'b0, 0, 3, 1'b1);
        doInstr(6'h3F, 1'b0, 0, 0, 1'b1);
        doInstr(LW, 1'b0, 4, 0, 1'b1);
        doInstr(SW, 1'b0, 0, 5, 1'b1);

        // Reset while waiting in MEMRD abandons the load.
        curOp = LW;
        curZero = 1'b0;
        memPhase(FETCH, 0, 1'b1, tr);
        begin
            ctl_t c;
            c = busyCtl(); c.srcB = 2'b11;
            push(DECODE, c, 1'b1, 1'b1);
            c = busyCtl(); c.srcA = 1'b1; c.srcB = 2'b10;
            push(MEMADR, c, 1'b1, 1'b1);
            pushReset(MEMRD);
            push(IDLE, '0, 1'b1, 1'b0);
            push(IDLE, '0, 1'b1, 1'b1);
        end

        for (int n = 0; n < 80; n++) begin
            doInstr(ops[$urandom_range(0, 6)], rbit(), randStall(), randStall(), ($urandom_range(0, 4) != 0));
        end

        for (int k = 0; q.size() > 0; k++) begin
            s = q.pop_front();
            @(posedge clk);
            #1;
            reset = s.rst; run = s.run; mem_ready = s.rdy; zero = s.zero; opcode = s.op;
            @(negedge clk);
            if (s.chk) begin
                act = {pc_en, pc_src, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
                       reg_write, alu_src_a, alu_src_b, alu_op, busy};
                nCmp++;
                assert (state_dbg === s.st) else begin
                    nBad++;
                    $error("FAIL state step=%0d got=%0d exp=%0d", k, state_dbg, s.st);
                end
                nCmp++;
                assert (act === s.ctl) else begin
                    nBad++;
                    $error("FAIL ctl step=%0d st=%0d got=%h exp=%h", k, s.st, act, s.ctl);
                end
                nCmp++;
                assert ({illegal_op, mem_err} === {s.ill, s.err}) else begin
                    nBad++;
                    $error("FAIL flags step=%0d got=%b%b exp=%b%b", k, illegal_op, mem_err, s.ill, s.err);
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
